// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and read-latency limits.
package lsu_pkg;

   localparam logic [1:0] LSU_SIZE_BYTE = 2'b00;
   localparam logic [1:0] LSU_SIZE_HALF = 2'b01;
   localparam logic [1:0] LSU_SIZE_WORD = 2'b10;
   localparam logic [1:0] LSU_SIZE_RSVD = 2'b11;

   localparam int LSU_MAX_READ_LATENCY = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_RESP  = 2'd3
   } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Big-endian lane steering: extracts and extends sub-word loads and merges sub-word
// store data into the aligned word read back from memory.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [31:0] rd_word,
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        is_signed,
   input  logic [31:0] st_data,
   output logic [31:0] load_value,
   output logic [31:0] store_word
);

   logic [4:0]  byte_shift;
   logic [4:0]  half_shift;
   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic [31:0] byte_mask;
   logic [31:0] half_mask;

   always_comb begin
      // Offset 0 is the most significant byte, so the shift is 8*(3-offset).
      byte_shift = {~offset, 3'b000};
      half_shift = offset[1] ? 5'd0 : 5'd16;
      byte_lane  = 8'(rd_word >> byte_shift);
      half_lane  = 16'(rd_word >> half_shift);
      byte_mask  = 32'h0000_00FF << byte_shift;
      half_mask  = 32'h0000_FFFF << half_shift;
      load_value = rd_word;
      store_word = st_data;
      case (size)
         LSU_SIZE_BYTE: begin
            load_value = {{24{is_signed & byte_lane[7]}}, byte_lane};
            store_word = (rd_word & ~byte_mask) | ({24'd0, st_data[7:0]} << byte_shift);
         end
         LSU_SIZE_HALF: begin
            load_value = {{16{is_signed & half_lane[15]}}, half_lane};
            store_word = (rd_word & ~half_mask) | ({16'd0, st_data[15:0]} << half_shift);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: byte/half/word loads and stores, sub-word stores as read-modify-write.
// Optional error counter output errCount enabled by defining LSU_ERR_COUNT_EN.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_WIDTH       = 8,
   parameter int MEM_READ_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        reqValid,
   output logic        reqReady,
   input  logic        reqWrite,
   input  logic [1:0]  reqSize,
   input  logic        reqSigned,
   input  logic [31:0] reqAddress,
   input  logic [31:0] reqData,
   output logic        respValid,
   output logic [31:0] respData,
   output logic        respError,
`ifdef LSU_ERR_COUNT_EN
   output logic [15:0] errCount,
`endif
   output logic [31:0] memAddress,
   output logic [31:0] memWriteData,
   output logic        MemRead,
   output logic        MemWrite,
   input  logic [31:0] memReadData
);

   localparam int RD_LAT = (MEM_READ_LATENCY > LSU_MAX_READ_LATENCY) ? LSU_MAX_READ_LATENCY :
                           (MEM_READ_LATENCY < 1) ? 1 : MEM_READ_LATENCY;

   lsu_state_e  state_q, state_d;
   logic        wr_q, wr_d;
   logic [1:0]  size_q, size_d;
   logic        sgn_q, sgn_d;
   logic [1:0]  off_q, off_d;
   logic [31:0] data_q, data_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        mem_read_q, mem_read_d;
   logic        mem_write_q, mem_write_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] resp_data_q, resp_data_d;
   logic        resp_error_q, resp_error_d;

   logic        req_err;
   logic [31:0] load_value;
   logic [31:0] store_word;

   lsu_lane_align u_align (
      .rd_word    (memReadData),
      .offset     (off_q),
      .size       (size_q),
      .is_signed  (sgn_q),
      .st_data    (data_q),
      .load_value (load_value),
      .store_word (store_word)
   );

   always_comb begin
      req_err = (reqSize == LSU_SIZE_RSVD)
              || (reqSize == LSU_SIZE_HALF && reqAddress[0])
              || (reqSize == LSU_SIZE_WORD && reqAddress[1:0] != 2'b00)
              || ((reqAddress >> ADDR_WIDTH) != 32'd0);
   end

   always_comb begin
      state_d      = state_q;
      wr_d         = wr_q;
      size_d       = size_q;
      sgn_d        = sgn_q;
      off_d        = off_q;
      data_d       = data_q;
      cnt_d        = cnt_q;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      resp_valid_d = 1'b0;
      resp_data_d  = resp_data_q;
      resp_error_d = resp_error_q;
      case (state_q)
         ST_IDLE: begin
            if (reqValid) begin
               wr_d   = reqWrite;
               size_d = reqSize;
               sgn_d  = reqSigned;
               off_d  = reqAddress[1:0];
               data_d = reqData;
               if (req_err) begin
                  state_d      = ST_RESP;
                  resp_valid_d = 1'b1;
                  resp_error_d = 1'b1;
                  resp_data_d  = 32'd0;
               end else if (reqWrite && reqSize == LSU_SIZE_WORD) begin
                  state_d     = ST_WRITE;
                  mem_write_d = 1'b1;
                  mem_addr_d  = {reqAddress[31:2], 2'b00};
                  mem_wdata_d = reqData;
               end else begin
                  state_d    = ST_READ;
                  mem_read_d = 1'b1;
                  mem_addr_d = {reqAddress[31:2], 2'b00};
                  cnt_d      = 2'(RD_LAT - 1);
               end
            end
         end
         ST_READ: begin
            // memReadData is consumed directly at the edge that ends the last read cycle.
            if (cnt_q == 2'd0) begin
               if (wr_q) begin
                  state_d     = ST_WRITE;
                  mem_write_d = 1'b1;
                  mem_wdata_d = store_word;
               end else begin
                  state_d      = ST_RESP;
                  resp_valid_d = 1'b1;
                  resp_error_d = 1'b0;
                  resp_data_d  = load_value;
               end
            end else begin
               cnt_d      = cnt_q - 2'd1;
               mem_read_d = 1'b1;
            end
         end
         ST_WRITE: begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b0;
            resp_data_d  = 32'd0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         wr_q         <= 1'b0;
         size_q       <= LSU_SIZE_BYTE;
         sgn_q        <= 1'b0;
         off_q        <= 2'd0;
         data_q       <= 32'd0;
         cnt_q        <= 2'd0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_addr_q   <= 32'd0;
         mem_wdata_q  <= 32'd0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= 32'd0;
         resp_error_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_q         <= wr_d;
         size_q       <= size_d;
         sgn_q        <= sgn_d;
         off_q        <= off_d;
         data_q       <= data_d;
         cnt_q        <= cnt_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         resp_error_q <= resp_error_d;
      end
   end

`ifdef LSU_ERR_COUNT_EN
   logic [15:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (resp_valid_q && resp_error_q && err_cnt_q != 16'hFFFF)
         err_cnt_d = err_cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) err_cnt_q <= 16'd0;
      else        err_cnt_q <= err_cnt_d;
   end

   assign errCount = err_cnt_q;
`endif

   assign reqReady     = rst_n && (state_q == ST_IDLE);
   assign respValid    = resp_valid_q;
   assign respData     = resp_data_q;
   assign respError    = resp_error_q;
   assign memAddress   = mem_addr_q;
   assign memWriteData = mem_wdata_q;
   assign MemRead      = mem_read_q;
   assign MemWrite     = mem_write_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: accepts byte/half/word load and store requests from the execute stage and drives MemRead/MemWrite, address and write data into the byte-addressed, big-endian data memory.
- Extracts and sign/zero-extends sub-word loads.
- Performs sub-word stores as read-modify-write of the aligned word.
- Flags misaligned or out-of-range accesses without touching memory.

Parameters:
- ADDR_WIDTH, 8, byte-address bits implemented by data memory (256 bytes); higher address bits must be zero.
- MEM_READ_LATENCY, 1, cycles MemRead is held before memReadData is sampled (range 1..4).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- reqValid  input  1  request present.
- reqReady  output  1  unit idle and able to accept; 1 only in IDLE and while rst_n=1.
- reqWrite  input  1  1=store, 0=load.
- reqSize  input  2  00 byte, 01 half, 10 word, 11 reserved.
- reqSigned  input  1  sign-extend sub-word load.
- reqAddress  input  32  byte address.
- reqData  input  32  store data, right-justified.
- respValid  output  1  one-cycle completion pulse; no backpressure.
- respData  output  32  load result (0 for stores and errors).
- respError  output  1  misaligned, out-of-range or reserved size; valid with respValid.
- memAddress  output  32  word-aligned byte address to memory (low 2 bits always 0).
- memWriteData  output  32  word to memory, bits[31:24] = byte at memAddress.
- MemRead  output  1  memory read strobe.
- MemWrite  output  1  memory write strobe.
- memReadData  input  32  word from memory, big-endian.

Behaviour:
- Reset: any clk edge with rst_n=0 forces IDLE and clears MemRead, MemWrite, memAddress, memWriteData, respValid, respData, respError. reqReady=0 while rst_n=0. A reset mid-operation abandons the access, and no response is ever issued for it.
- Accept: on an edge with reqValid & reqReady, the request is registered and reqReady drops the next cycle.
- Checks, done at accept:
  - half with addr[0]=1 is an error;
  - word with addr[1:0]!=0 is an error;
  - reqSize=11 is an error;
  - any reqAddress bit at or above ADDR_WIDTH set is an error.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE transitions:
  - error -> RESP;
  - load -> READ;
  - word store -> WRITE;
  - byte/half store -> READ.
- READ:
  - MemRead=1 and memAddress = {addr[31:2],2'b00} for MEM_READ_LATENCY cycles (down-counter).
  - memReadData is captured at the edge ending the last cycle.
  - Next state is RESP for a load, WRITE for a sub-word store.
- WRITE:
  - MemWrite=1 for exactly one cycle.
  - memWriteData is reqData for a word store, otherwise the captured word with the target lane replaced; all other bytes are unchanged.
  - Next state: RESP.
- RESP: respValid=1 for one cycle, then IDLE. reqReady returns high the following cycle; there is no back-to-back accept in RESP.
- MemRead and MemWrite are never both 1 in the same cycle.
- Lane map (big-endian): byte at offset k occupies word[31-8k -: 8]; half at offset 0 is [31:16], at offset 2 is [15:0].
- Load result: lane right-justified; upper bits sign-extended if reqSigned, else zero. reqSigned is ignored for word loads.
- Latency from accept edge to respValid, in cycles:
  - load: 1+MEM_READ_LATENCY;
  - word store: 2;
  - sub-word store: 2+MEM_READ_LATENCY;
  - error: 1.
- reqWrite, reqSize and the other request fields are sampled only at accept; changes while busy are ignored.

Optional Feature:
- Macro LSU_ERR_COUNT_EN.
- When defined: extra output errCount[15:0], reset to 0, increments on each respValid&respError, saturates at 16'hFFFF.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package lsu_pkg:
  - size encodings LSU_SIZE_BYTE/HALF/WORD/RSVD;
  - FSM state enum;
  - MEM_READ_LATENCY limit constant.
- Sub-module lsu_lane_align: purely combinational; given word, offset, size and signed it produces the extracted load value, and given old word, new data, offset and size it produces the merged store word.
- The FSM and counter stay in load_store_unit.

Test Plan:
- Word store then load, addr 20, data 32'd50, LAT=1:
  - MemWrite one cycle with memAddress=20, memWriteData=50;
  - the load returns respData=50, respError=0, respValid 2 cycles after accept.
- Signed byte load: memory[20..23]=80 12 34 56, load byte addr 20 signed -> FFFFFF80; unsigned -> 00000080; byte addr 23 -> 00000056.
- Half store 16'hBEEF to addr 22 over 80123456: one READ of addr 20 then one WRITE of 8012BEEF; memory bytes 20-21 unchanged; respValid at LAT+2.
- Misaligned word addr 21 and half addr 23, plus address 32'h100 (ADDR_WIDTH=8): respValid after 1 cycle with respError=1, MemRead and MemWrite stay 0.
- Reset asserted during READ of a load: the next edge gives MemRead=0 and IDLE, no respValid ever; reqReady=1 the first cycle after rst_n=1.
- LSU_ERR_COUNT_EN: 3 error requests and 2 good ones -> errCount=3; reset clears it to 0.
